// File: rtl/tdm_pkg.sv
// Shared types and default sizing for the TDM demultiplexer.
package tdm_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } tdm_state_e;

  localparam int TDM_NUM_CH = 4;
  localparam int TDM_DATA_W = 8;

  // Width of a slot index for n channels; never narrower than one bit.
  function automatic int slot_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter: load-to-1 on a frame start, wraps NUM_CH-1 -> 0.
module tdm_slot_ctr
  import tdm_pkg::*;
#(
  parameter int NUM_CH = TDM_NUM_CH,
  parameter int SLOT_W = slot_w(TDM_NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_one,
  input  logic              incr,
  output logic [SLOT_W-1:0] slot
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);
  localparam logic [SLOT_W-1:0] ONE       = SLOT_W'(1);

  // Load wins over increment so an SOF always restarts the frame at slot 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot <= '0;
    end else if (load_one) begin
      slot <= ONE;
    end else if (incr) begin
      slot <= (slot == LAST_SLOT) ? '0 : slot + ONE;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: spreads a slotted sample stream across NUM_CH
// registered channel outputs, tracking frame alignment via in_sof.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   HUNT  | not aligned; non-SOF beats dropped, waiting for an SOF
//   LOCK  | aligned; each beat lands in the slot the counter points at
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NUM_CH = TDM_NUM_CH,
  parameter int DATA_W = TDM_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_sof,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_valid,
  output logic                     frame_done,
  output logic                     sync_err,
  output logic                     locked
);

  localparam int SLOT_W = slot_w(NUM_CH);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);

  tdm_state_e        state;
  logic [SLOT_W-1:0] slot;
  logic              ctr_load_one;
  logic              ctr_incr;
  logic [NUM_CH-1:0] slot_onehot;

  // Counter controls: any accepted SOF restarts at 1; in-frame beats advance.
  // A beat at slot 0 without SOF is a framing error and leaves the count at 0.
  always_comb begin
    ctr_load_one = 1'b0;
    ctr_incr     = 1'b0;
    if (!reset && in_valid) begin
      if (in_sof) begin
        ctr_load_one = 1'b1;
      end else if (state == LOCK && slot != '0) begin
        ctr_incr = 1'b1;
      end
    end
  end

  // Strobe pattern for the slot currently addressed by the counter.
  always_comb begin
    slot_onehot       = '0;
    slot_onehot[slot] = 1'b1;
  end

  tdm_slot_ctr #(
    .NUM_CH (NUM_CH),
    .SLOT_W (SLOT_W)
  ) u_slot_ctr (
    .clk      (clk),
    .reset    (reset),
    .load_one (ctr_load_one),
    .incr     (ctr_incr),
    .slot     (slot)
  );

  // Framing FSM with all outputs registered; strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      locked     <= 1'b0;
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (in_valid) begin
        unique case (state)
          HUNT: begin
            if (in_sof) begin
              ch_data[0 +: DATA_W] <= in_data;
              ch_valid             <= NUM_CH'(1);
              state                <= LOCK;
              locked               <= 1'b1;
            end
          end
          LOCK: begin
            if (in_sof) begin
              // Early SOF restarts the frame; the truncated one never completes.
              ch_data[0 +: DATA_W] <= in_data;
              ch_valid             <= NUM_CH'(1);
              sync_err             <= (slot != '0);
            end else if (slot == '0) begin
              sync_err <= 1'b1;
              state    <= HUNT;
              locked   <= 1'b0;
            end else begin
              ch_data[int'(slot)*DATA_W +: DATA_W] <= in_data;
              ch_valid                             <= slot_onehot;
              frame_done                           <= (slot == LAST_SLOT);
            end
          end
          default: begin
            state  <= HUNT;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux at the default 4 x 8-bit configuration.
module tb_tdm_demux;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;

  logic                     clk;
  logic                     reset;
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     in_sof;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [NUM_CH-1:0]        ch_valid;
  logic                     frame_done;
  logic                     sync_err;
  logic                     locked;

  int n_cmp = 0;
  int n_err = 0;

  tdm_demux #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, let a rising edge pass, return at the falling edge.
  task automatic step(input logic v, input logic sof, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_sof   = sof;
    in_data  = d;
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] data, input logic [3:0] vld,
                         input logic fd, input logic se, input logic lk);
    chk({tag, ".ch_data"},    64'(ch_data),    64'(data));
    chk({tag, ".ch_valid"},   64'(ch_valid),   64'(vld));
    chk({tag, ".frame_done"}, 64'(frame_done), 64'(fd));
    chk({tag, ".sync_err"},   64'(sync_err),   64'(se));
    chk({tag, ".locked"},     64'(locked),     64'(lk));
  endtask

  initial begin
    logic [7:0]  gap_d [4];
    logic [31:0] exp_data;
    gap_d[0] = 8'h10; gap_d[1] = 8'h20; gap_d[2] = 8'h30; gap_d[3] = 8'h40;

    reset = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    @(negedge clk);
    step(1'b1, 1'b1, 8'hEE);  // beat during reset is ignored
    chk_all("reset", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // Clean frame from reset
    step(1'b1, 1'b1, 8'h11); chk_all("f1.s0", 32'h0000_0011, 4'b0001, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h22); chk_all("f1.s1", 32'h0000_2211, 4'b0010, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h33); chk_all("f1.s2", 32'h0033_2211, 4'b0100, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h44); chk_all("f1.s3", 32'h4433_2211, 4'b1000, 1'b1, 1'b0, 1'b1);

    // Missing SOF on the fifth beat drops lock, data untouched
    step(1'b1, 1'b0, 8'h55); chk_all("miss_sof", 32'h4433_2211, 4'b0000, 1'b0, 1'b1, 1'b0);

    // HUNT discards non-SOF beats, then reacquires
    step(1'b1, 1'b0, 8'hAA); chk_all("hunt.aa", 32'h4433_2211, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hBB); chk_all("hunt.bb", 32'h4433_2211, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h01); chk_all("hunt.sof", 32'h4433_2201, 4'b0001, 1'b0, 1'b0, 1'b1);

    // Early SOF on the third beat of a frame
    step(1'b1, 1'b0, 8'h02); chk_all("early.s1", 32'h4433_0201, 4'b0010, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'hA0); chk_all("early.sof", 32'h4433_02A0, 4'b0001, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'hB1); chk_all("early.s1b", 32'h4433_B1A0, 4'b0010, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'hC2); chk_all("early.s2b", 32'h44C2_B1A0, 4'b0100, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'hD3); chk_all("early.s3b", 32'hD3C2_B1A0, 4'b1000, 1'b1, 1'b0, 1'b1);

    // Gapped frame: 3 idle cycles (with a stray SOF level) after each beat
    exp_data = 32'hD3C2_B1A0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 0), gap_d[i]);
      exp_data[i*8 +: 8] = gap_d[i];
      chk_all($sformatf("gap.beat%0d", i), exp_data, 4'(1 << i), (i == 3), 1'b0, 1'b1);
      for (int g = 0; g < 3; g++) begin
        step(1'b0, 1'b1, 8'hFF);
        chk_all($sformatf("gap.idle%0d_%0d", i, g), exp_data, 4'b0000, 1'b0, 1'b0, 1'b1);
      end
    end

    // Reset mid-frame, then a SOF-less beat must be ignored
    step(1'b1, 1'b1, 8'h5A); chk_all("rst.s0", 32'h4030_205A, 4'b0001, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h6B); chk_all("rst.s1", 32'h4030_6B5A, 4'b0010, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    step(1'b1, 1'b0, 8'h7C); chk_all("rst.mid", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step(1'b1, 1'b0, 8'h99); chk_all("rst.nosof", 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h77); chk_all("rst.sof", 32'h0000_0077, 4'b0001, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
